alu_status_flags: RTL and testbench

Registered, parametrised status-flag unit for the ALU datapath. Sits after the adder/subtractor and result mux. Per accepted operation it selects the overflow and carry source by opcode and derives zero/negative from the result. It also keeps a sticky overflow flag and a saturating overflow-event counter for software polling, and can optionally raise an interrupt pulse.

---
 rtl/alu_status_flags.sv | 179 +++++++++++++++++
 tb/tb_alu_status_flags.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_status_flags.sv
// ---------------------------------------------------------------------------
// alu_status_flags
//
// Registered status-flag unit placed after the ALU adder/subtractor and the
// result mux. For every accepted operation it picks the overflow and carry
// sources by opcode and derives zero/negative from the result. It also keeps
// a sticky overflow flag and a saturating overflow-event counter for
// software polling.
//
// Optional feature macro: ALU_OVF_IRQ_EN
//   When defined, adds the ovf_irq output: a registered one-cycle pulse on
//   the edge where the sticky overflow flag becomes set (or is re-armed by a
//   same-cycle clear).
//
// Parameters:
//   WIDTH  result datapath width (>= 2)
//   CNT_W  overflow event counter width (>= 1)
//
// Ports:
//   clk         clock, rising-edge
//   rst_n       asynchronous active-low reset
//   in_valid    operation present this cycle
//   sel         opcode: 3'b000 add, 3'b001 sub, others non-arithmetic
//   result      ALU result for this operation
//   add_ovf     adder signed overflow
//   sub_ovf     subtractor signed overflow
//   add_cout    adder carry-out
//   sub_bout    subtractor borrow-out
//   clr_sticky  synchronous clear of sticky flag and counter
//   out_valid   one-cycle pulse, flags updated
//   ovf         overflow of last accepted op
//   carry       carry/borrow of last accepted op
//   zero        result of last accepted op was zero
//   neg         sign bit of last accepted result
//   ovf_sticky  set by any overflow since last clear
//   ovf_count   saturating count of overflowing ops
//   ovf_irq     overflow interrupt pulse (ALU_OVF_IRQ_EN only)
// ---------------------------------------------------------------------------
module alu_status_flags #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] result,
  input  logic             add_ovf,
  input  logic             sub_ovf,
  input  logic             add_cout,
  input  logic             sub_bout,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic             ovf,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
`ifdef ALU_OVF_IRQ_EN
  ,
  output logic             ovf_irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_d, out_valid_q;
  logic             ovf_d, ovf_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;
  logic             ovf_sticky_d, ovf_sticky_q;
  logic [CNT_W-1:0] ovf_count_d, ovf_count_q;
  logic             ovf_irq_d, ovf_irq_q;

  logic             ovf_n;
  logic             carry_n;
  logic             ovf_event;

  // Opcode-based source selection. Gated by in_valid so an unknown sel
  // while idle cannot reach any state.
  always_comb begin
    ovf_n   = 1'b0;
    carry_n = 1'b0;
    if (in_valid) begin
      case (sel)
        3'b000: begin
          ovf_n   = add_ovf;
          carry_n = add_cout;
        end
        3'b001: begin
          ovf_n   = sub_ovf;
          carry_n = sub_bout;
        end
        default: begin
          ovf_n   = 1'b0;
          carry_n = 1'b0;
        end
      endcase
    end
  end

  assign ovf_event = in_valid & ovf_n;

  always_comb begin
    out_valid_d  = in_valid;
    ovf_d        = ovf_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    neg_d        = neg_q;
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    ovf_irq_d    = 1'b0;

    if (in_valid) begin
      ovf_d   = ovf_n;
      carry_d = carry_n;
      zero_d  = (result == '0);
      neg_d   = result[WIDTH-1];
    end

    // A same-cycle clear and overflow resolves as "clear, then count this
    // event", so set wins and the counter restarts at one.
    if (ovf_event) begin
      ovf_sticky_d = 1'b1;
      if (clr_sticky) begin
        ovf_count_d = CNT_W'(1);
      end else if (ovf_count_q != CNT_MAX) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
      // The clear re-arms the interrupt, so a collision pulses even when
      // the sticky flag was already high.
      ovf_irq_d = ~ovf_sticky_q | clr_sticky;
    end else if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
      ovf_irq_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      ovf_q        <= ovf_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      neg_q        <= neg_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
      ovf_irq_q    <= ovf_irq_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign ovf        = ovf_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign neg        = neg_q;
  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

`ifdef ALU_OVF_IRQ_EN
  assign ovf_irq = ovf_irq_q;
`else
  // Without the interrupt feature the pulse register has no consumer.
  logic unused_irq;
  assign unused_irq = ovf_irq_q;
`endif

endmodule

// File: tb/tb_alu_status_flags.sv
// ---------------------------------------------------------------------------
// tb_alu_status_flags
//
// Self-checking bench for alu_status_flags with WIDTH=8, CNT_W=2. A
// behavioural reference model tracks the expected flags; directed scenarios
// are followed by a randomized sequence and a mid-stream asynchronous reset.
// ---------------------------------------------------------------------------
module tb_alu_status_flags;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [2:0]       sel;
  logic [WIDTH-1:0] result;
  logic             add_ovf;
  logic             sub_ovf;
  logic             add_cout;
  logic             sub_bout;
  logic             clr_sticky;
  logic             out_valid;
  logic             ovf;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;
`ifdef ALU_OVF_IRQ_EN
  logic             ovf_irq;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_vld, m_ovf, m_carry, m_zero, m_neg, m_sticky, m_irq;
  int m_cnt;

  alu_status_flags #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .sel        (sel),
    .result     (result),
    .add_ovf    (add_ovf),
    .sub_ovf    (sub_ovf),
    .add_cout   (add_cout),
    .sub_bout   (sub_bout),
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid),
    .ovf        (ovf),
    .carry      (carry),
    .zero       (zero),
    .neg        (neg),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
`ifdef ALU_OVF_IRQ_EN
    ,
    .ovf_irq    (ovf_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, m_vld});
    chk({tag, ".ovf"},        {31'd0, ovf},        {31'd0, m_ovf});
    chk({tag, ".carry"},      {31'd0, carry},      {31'd0, m_carry});
    chk({tag, ".zero"},       {31'd0, zero},       {31'd0, m_zero});
    chk({tag, ".neg"},        {31'd0, neg},        {31'd0, m_neg});
    chk({tag, ".ovf_sticky"}, {31'd0, ovf_sticky}, {31'd0, m_sticky});
    chk({tag, ".ovf_count"},  32'(ovf_count),      32'(m_cnt));
`ifdef ALU_OVF_IRQ_EN
    chk({tag, ".ovf_irq"},    {31'd0, ovf_irq},    {31'd0, m_irq});
`endif
  endtask

  task automatic model_reset();
    m_vld = 0; m_ovf = 0; m_carry = 0; m_zero = 0; m_neg = 0;
    m_sticky = 0; m_irq = 0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs, advance past the edge, update model, check.
  task automatic step(input string tag, input logic v, input logic [2:0] s,
                      input logic [7:0] r, input logic ao, input logic so,
                      input logic ac, input logic sb, input logic clr);
    bit o_n, c_n;
    in_valid = v; sel = s; result = r; add_ovf = ao; sub_ovf = so;
    add_cout = ac; sub_bout = sb; clr_sticky = clr;
    @(posedge clk);
    o_n = 0; c_n = 0;
    if (v) begin
      if (s == 3'd0)      begin o_n = ao; c_n = ac; end
      else if (s == 3'd1) begin o_n = so; c_n = sb; end
      m_ovf = o_n; m_carry = c_n;
      m_zero = (r == 0);
      m_neg = (r >= 8'd128);
    end
    m_vld = v;
    m_irq = 0;
    if (v && o_n) begin
      m_irq = !m_sticky || clr;
      m_sticky = 1;
      m_cnt = clr ? 1 : ((m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1);
    end else if (clr) begin
      m_sticky = 0;
      m_cnt = 0;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; sel = 0; result = 0; add_ovf = 0; sub_ovf = 0;
    add_cout = 0; sub_bout = 0; clr_sticky = 0;
    model_reset();
    #3;
    chk_all("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Add with overflow
    step("add_ovf", 1, 3'b000, 8'h80, 1, 0, 0, 0, 0);
    // Subtract producing zero with borrow
    step("sub_zero", 1, 3'b001, 8'h00, 0, 0, 0, 1, 0);
    // Non-arithmetic op ignores add_ovf
    step("nonarith", 1, 3'b101, 8'h12, 1, 1, 1, 1, 0);

    // Clear, then saturation with five overflowing adds
    step("clr1", 0, 3'b000, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step("sat", 1, 3'b000, 8'h7f, 1, 0, 1, 0, 0);

    // Clear colliding with an overflowing add, then clear alone
    step("collide", 1, 3'b000, 8'h01, 1, 0, 0, 0, 1);
    step("clr_alone", 0, 3'b000, 8'h00, 0, 0, 0, 0, 1);

    // Hold for three idle cycles with an unknown opcode
    step("load", 1, 3'b001, 8'hc3, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step("hold", 0, 3'bxxx, 8'hff, 1, 1, 1, 1, 0);

    // First overflow after clear pulses, second does not
    step("irq_first", 1, 3'b001, 8'h40, 0, 1, 0, 0, 0);
    step("irq_second", 1, 3'b000, 8'h40, 1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rv;
      logic [2:0]  rs;
      rv = $urandom;
      rs = (rv[2:1] != 2'b11) ? {2'b00, rv[0]} : rv[5:3];
      step("rand", rv[6] | rv[7], rs, (rv[8] ? 8'h00 : rv[23:16]),
           rv[9], rv[10], rv[11], rv[12], (rv[15:13] == 3'd0));
    end

    // Asynchronous reset asserted mid-cycle with an op in flight
    in_valid = 1; sel = 3'b000; result = 8'h85; add_ovf = 1; add_cout = 1;
    clr_sticky = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst");
    @(posedge clk); #1;
    chk_all("rst_held");
    rst_n = 1'b1;
    step("post_rst", 1, 3'b000, 8'h80, 1, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
